// File: rtl/pixel_writer.sv
// Clips an X/Y/colour pixel stream against the screen and queues on-screen pixels.
// Each queued pixel is written to the framebuffer through a held req/ack handshake.
module pixel_writer #(
    parameter int SCR_W      = 160,
    parameter int SCR_H      = 120,
    parameter int COLOR_W    = 8,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               ACLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [7:0]         X_In,
    input  logic [7:0]         Y_In,
    input  logic [COLOR_W-1:0] Color,
    output logic               Ready,
    output logic [ADDR_W-1:0]  FB_Addr,
    output logic [COLOR_W-1:0] FB_Data,
    output logic               FB_WE,
    input  logic               FB_Ack,
    output logic               Idle,
    output logic [15:0]        Clip_Cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pix_t;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    pix_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    state_t             state_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [COLOR_W-1:0] data_q;
    logic [15:0]        clip_q;

    logic               ready, clipped, push, clip_hit, not_empty, pop;
    pix_t               wr_pix, head;

    assign ready     = cnt_q != CNT_W'(FIFO_DEPTH);
    assign clipped   = (32'(X_In) >= SCR_W) || (32'(Y_In) >= SCR_H);
    assign push      = EN && ready && !clipped;
    assign clip_hit  = EN && ready && clipped;
    assign not_empty = cnt_q != '0;
    // In S_IDLE the head is loaded unconditionally; in S_WRITE only once the current write is acked.
    assign pop       = not_empty && ((state_q == S_IDLE) || FB_Ack);
    assign cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
    assign head      = mem_q[rd_ptr_q];

    assign wr_pix.addr  = ADDR_W'(Y_In) * ADDR_W'(SCR_W) + ADDR_W'(X_In);
    assign wr_pix.color = Color;

    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= wr_pix;
    end

    always_ff @(posedge ACLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            clip_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (clip_hit && clip_q != 16'hFFFF) clip_q <= clip_q + 16'd1;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        addr_q  <= head.addr;
                        data_q  <= head.color;
                        we_q    <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (FB_Ack) begin
                        if (pop) begin
                            addr_q <= head.addr;
                            data_q <= head.color;
                        end else begin
                            we_q    <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    we_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Ready    = ready;
    assign FB_WE    = we_q;
    assign FB_Addr  = addr_q;
    assign FB_Data  = data_q;
    assign Idle     = (cnt_q == '0) && (state_q == S_IDLE);
    assign Clip_Cnt = clip_q;
endmodule

// File: tb/tb_pixel_writer.sv
// Bench for pixel_writer: queue-based reference of accepted pixels, per-cycle checks,
// directed scenarios plus random and midpoint-circle streams.
module tb_pixel_writer;
    localparam int DEPTH = 4;

    logic        ACLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic [7:0]  X_In = '0, Y_In = '0, Color = '0;
    logic        Ready, FB_WE, Idle;
    logic        FB_Ack = 1'b0;
    logic [14:0] FB_Addr;
    logic [7:0]  FB_Data;
    logic [15:0] Clip_Cnt;

    pixel_writer dut (
        .ACLK(ACLK), .RST(RST), .EN(EN), .X_In(X_In), .Y_In(Y_In), .Color(Color),
        .Ready(Ready), .FB_Addr(FB_Addr), .FB_Data(FB_Data), .FB_WE(FB_WE),
        .FB_Ack(FB_Ack), .Idle(Idle), .Clip_Cnt(Clip_Cnt)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: every accepted, on-screen pixel not yet acknowledged, in acceptance order.
    int          q_addr[$];
    int          q_col[$];
    int          m_clip = 0;
    int          wr_cnt = 0;
    int          last_addr = -1;
    bit          started = 0;
    bit          circ_on = 0;
    bit          got_set[int];
    bit          hold_pend = 0;
    logic [14:0] hold_a;
    logic [7:0]  hold_d;

    always @(negedge ACLK) begin
        if (started) begin
            chk("clip_cnt", 32'(Clip_Cnt), 32'(m_clip));
            chk("idle", 32'(Idle), 32'(q_addr.size() == 0));
            chk("ready", 32'(Ready), 32'((q_addr.size() - int'(FB_WE)) != DEPTH));
            if (hold_pend && !RST) begin
                chk("hold_we", 32'(FB_WE), 32'd1);
                chk("hold_addr", 32'(FB_Addr), 32'(hold_a));
                chk("hold_data", 32'(FB_Data), 32'(hold_d));
            end
            if (FB_WE && FB_Ack && !RST) begin
                if (q_addr.size() == 0) begin
                    chk("unexpected_write", 32'(FB_Addr), 32'hFFFF_FFFF);
                end else begin
                    chk("wr_addr", 32'(FB_Addr), 32'(q_addr.pop_front() & 32'h7FFF));
                    chk("wr_data", 32'(FB_Data), 32'(q_col.pop_front()));
                end
                wr_cnt++;
                last_addr = int'(FB_Addr);
                if (circ_on) got_set[int'(FB_Addr)] = 1'b1;
            end
            hold_pend = FB_WE && !FB_Ack && !RST;
            hold_a    = FB_Addr;
            hold_d    = FB_Data;
            if (RST) begin
                q_addr.delete();
                q_col.delete();
                m_clip = 0;
            end else if (EN && Ready) begin
                if (int'(X_In) >= 160 || int'(Y_In) >= 120) begin
                    if (m_clip < 65535) m_clip++;
                end else begin
                    q_addr.push_back(int'(Y_In) * 160 + int'(X_In));
                    q_col.push_back(int'(Color));
                end
            end
        end
    end

    // 0: never ack, 1: always ack, 2: every third cycle, 3: random
    int ack_mode = 1;
    int ack_div = 0;
    initial begin
        forever begin
            @(posedge ACLK);
            #2;
            case (ack_mode)
                0: FB_Ack = 1'b0;
                1: FB_Ack = 1'b1;
                2: begin ack_div++; FB_Ack = (ack_div % 3 == 0); end
                default: FB_Ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input int x, input int y, input int c);
        int  n = 0;
        bit  acc = 0;
        EN = 1'b1; X_In = 8'(x); Y_In = 8'(y); Color = 8'(c);
        do begin
            @(negedge ACLK);
            acc = Ready;
            @(posedge ACLK);
            #1;
            n++;
        end while (!acc && n < 500);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        EN = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(Idle && q_addr.size() == 0) && n < 2000) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        if (n >= 2000) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic plot(input int x, input int y, inout int cnt);
        send(x, y, 8'hFF);
        cnt++;
    endtask

    initial begin
        int w0, cx, cy, r, x, y, d, n;
        bit exp_set[int];
        int ex[8], ey[8];

        repeat (3) @(posedge ACLK);
        #1;
        started = 1;
        RST = 1'b0;
        @(negedge ACLK);
        chk("rst_ready", 32'(Ready), 32'd1);
        chk("rst_we", 32'(FB_WE), 32'd0);
        chk("rst_addr", 32'(FB_Addr), 32'd0);
        chk("rst_data", 32'(FB_Data), 32'd0);
        chk("rst_idle", 32'(Idle), 32'd1);
        chk("rst_clip", 32'(Clip_Cnt), 32'd0);

        // Single pixel: visible two edges after acceptance.
        @(posedge ACLK); #1;
        ack_mode = 1;
        EN = 1'b1; X_In = 8'd5; Y_In = 8'd2; Color = 8'h3C;
        @(posedge ACLK); #1;
        EN = 1'b0;
        @(negedge ACLK);
        chk("single_we_early", 32'(FB_WE), 32'd0);
        @(negedge ACLK);
        chk("single_we", 32'(FB_WE), 32'd1);
        chk("single_addr", 32'(FB_Addr), 32'd325);
        chk("single_data", 32'(FB_Data), 32'h3C);
        @(negedge ACLK);
        chk("single_idle", 32'(Idle), 32'd1);
        @(posedge ACLK); #1;

        // Clipping.
        w0 = wr_cnt;
        send(160, 0, 1); send(0, 120, 2); send(255, 255, 3); send(159, 119, 4);
        wait_idle();
        @(negedge ACLK);
        chk("clip_count", 32'(Clip_Cnt), 32'd3);
        chk("clip_writes", 32'(wr_cnt - w0), 32'd1);
        chk("clip_last_addr", 32'(last_addr), 32'd19199);
        @(posedge ACLK); #1;

        // Back-pressure: four buffered plus one held in the write stage.
        ack_mode = 0;
        @(posedge ACLK); #1;
        for (int i = 0; i < 5; i++) send(10 + i, 7, 8'h40 + i);
        @(negedge ACLK);
        chk("bp_ready", 32'(Ready), 32'd0);
        chk("bp_we", 32'(FB_WE), 32'd1);
        chk("bp_head", 32'(FB_Addr), 32'(7 * 160 + 10));
        @(posedge ACLK); #1;
        ack_mode = 1;
        w0 = wr_cnt;
        fork
            send(15, 7, 8'h45);
            begin
                repeat (6) @(posedge ACLK);
                #1;
                chk("bp_b2b_writes", 32'(wr_cnt - w0), 32'd6);
            end
        join
        wait_idle();

        // Handshake hold under sparse acks.
        ack_mode = 2;
        for (int i = 0; i < 6; i++) send($urandom_range(0, 159), $urandom_range(0, 119), $urandom);
        wait_idle();

        // Reset mid-write.
        ack_mode = 0;
        @(posedge ACLK); #1;
        send(1, 1, 8'h11); send(2, 1, 8'h12); send(200, 3, 8'h13); send(3, 1, 8'h14);
        @(negedge ACLK);
        chk("rw_we_before", 32'(FB_WE), 32'd1);
        @(posedge ACLK); #1;
        RST = 1'b1;
        @(posedge ACLK); #1;
        RST = 1'b0;
        @(negedge ACLK);
        chk("rw_we", 32'(FB_WE), 32'd0);
        chk("rw_idle", 32'(Idle), 32'd1);
        chk("rw_ready", 32'(Ready), 32'd1);
        chk("rw_clip", 32'(Clip_Cnt), 32'd0);
        w0 = wr_cnt;
        ack_mode = 1;
        repeat (10) @(posedge ACLK);
        #1;
        chk("rw_no_writes", 32'(wr_cnt - w0), 32'd0);

        // Random stream with random stalls.
        ack_mode = 3;
        for (int i = 0; i < 150; i++) begin
            send($urandom_range(0, 199), $urandom_range(0, 149), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge ACLK);
            #1;
        end
        wait_idle();

        // Midpoint circle at (20,20), R=5.
        got_set.delete();
        circ_on = 1;
        cx = 20; cy = 20; r = 5;
        x = 0; y = r; d = 1 - r; n = 0;
        while (x <= y) begin
            ex = '{cx + x, cx - x, cx + x, cx - x, cx + y, cx - y, cx + y, cx - y};
            ey = '{cy + y, cy + y, cy - y, cy - y, cy + x, cy + x, cy - x, cy - x};
            for (int k = 0; k < 8; k++) begin
                exp_set[ey[k] * 160 + ex[k]] = 1'b1;
                plot(ex[k], ey[k], n);
            end
            x++;
            if (d < 0) d += 2 * x + 1;
            else begin
                y--;
                d += 2 * (x - y) + 1;
            end
        end
        wait_idle();
        @(posedge ACLK); #1;
        circ_on = 0;
        chk("circle_set_size", 32'(got_set.size()), 32'(exp_set.size()));
        chk("circle_pt_top", 32'(exp_set.exists(25 * 160 + 20)), 32'd1);
        foreach (exp_set[a]) chk("circle_member", 32'(got_set.exists(a)), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Downstream consumer of the raster draw stages (DrawCircle, line drawer). Takes the per-cycle X/Y pixel stream and one colour value, and clips each pixel against the screen.
- Buffers accepted pixels in a small FIFO and writes each one to the framebuffer RAM port with a req/ack handshake.
- Absorbs framebuffer stalls so draw stages can run at one pixel per cycle until the FIFO fills.

Parameters:
- SCR_W, 160, visible screen width in pixels
- SCR_H, 120, visible screen height in pixels
- COLOR_W, 8, colour/data width written per pixel
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= SCR_W*SCR_H
- FIFO_DEPTH, 4, pixel buffer entries; power of two, >= 2

Ports:
- ACLK, input, 1, system clock; all logic on rising edge
- RST, input, 1, synchronous active-high reset
- EN, input, 1, pixel valid from draw stage
- X_In, input, 8, pixel X coordinate
- Y_In, input, 8, pixel Y coordinate
- Color, input, COLOR_W, pixel colour, sampled with EN
- Ready, output, 1, block can accept a pixel this cycle
- FB_Addr, output, ADDR_W, framebuffer write address
- FB_Data, output, COLOR_W, framebuffer write data
- FB_WE, output, 1, write request; held until acknowledged
- FB_Ack, input, 1, framebuffer accepted the write this cycle
- Idle, output, 1, FIFO empty and no write outstanding
- Clip_Cnt, output, 16, count of discarded off-screen pixels

Behaviour:
- Reset values:
  - Ready=1, FB_WE=0, FB_Addr=0, FB_Data=0, Idle=1, Clip_Cnt=0.
  - FIFO pointers and count = 0; FSM = S_IDLE.
- Ready = (fifo_count != FIFO_DEPTH). It is combinational from registered count and never depends on EN.
- Accept condition: EN && Ready on a rising edge. EN while Ready=0 is ignored; the draw stage must hold the pixel.
- Clipping:
  - An accepted pixel with X_In >= SCR_W or Y_In >= SCR_H is discarded and not enqueued.
  - Clip_Cnt increments by 1 for each such pixel and saturates at 16'hFFFF.
- Address: Y_In*SCR_W + X_In, computed at enqueue, unsigned, truncated to ADDR_W. Each FIFO entry stores {addr, colour}.
- FSM states:
  - S_IDLE: FB_WE=0. If FIFO non-empty, pop head into FB_Addr/FB_Data, set FB_WE=1, go to S_WRITE.
  - S_WRITE: FB_WE=1, with FB_Addr/FB_Data stable. On FB_Ack:
    - FIFO non-empty: pop next entry in the same cycle, stay in S_WRITE (back-to-back, one write per cycle when Ack is held high).
    - FIFO empty: FB_WE=0, go to S_IDLE.
- Latency: a pixel accepted into an empty FIFO while in S_IDLE shows up on FB_WE/FB_Addr two edges after acceptance (edge 1 enqueue, edge 2 pop). There is no combinational bypass.
- Simultaneous push and pop:
  - Count stays unchanged.
  - When full, a pop frees a slot only on the next cycle (Ready is registered-count based), so the draw stage sees one extra stall cycle.
- FB_Ack while FB_WE=0 is ignored.
- Idle = (fifo_count == 0) && (state == S_IDLE).
- Ordering: pixels reach the framebuffer in acceptance order; no coalescing of duplicate addresses.
- Reset mid-operation:
  - RST=1 aborts any outstanding write. FB_WE=0 after that edge.
  - FIFO contents are discarded; Clip_Cnt is cleared.
  - Pixels presented while RST=1 are not accepted.
- Wrap: FIFO pointers wrap modulo FIFO_DEPTH; count is FIFO_DEPTH-aware (full vs empty are distinguished).

Test Plan:
- Single pixel: EN=1 one cycle, X=5, Y=2, Color=8'h3C, FB_Ack tied 1. Required: FB_WE=1 two edges later with FB_Addr=325 and FB_Data=8'h3C, then Idle=1 the following cycle.
- Clipping: pixels (160,0), (0,120), (255,255), (159,119). Required: Clip_Cnt=3 and exactly one write, at FB_Addr=19199.
- Back-pressure: FB_Ack=0 while 6 pixels are driven at 1/cycle. Required: Ready drops after 4 accepted entries plus the first popped into S_WRITE. Releasing FB_Ack gives writes in exact input order, one per cycle, with no loss or duplication.
- Handshake hold: FB_Ack pulsed every 3rd cycle. Required: FB_Addr/FB_Data stable whenever FB_WE=1 and FB_Ack=0.
- Reset mid-write: 3 pixels queued, FB_WE=1, RST asserted one cycle. Required: next cycle FB_WE=0, Idle=1, Ready=1, Clip_Cnt=0, and no further writes.
- Circle stream: connect to DrawCircle with centre (20,20), R=5, Color=8'hFF, and a random-stall FB_Ack. Required: the set of written addresses equals the reference-model circle pixel set, converted as Y*160+X.
